byte_word_packer: RTL and testbench

- Downstream consumer of the 8-bit registered byte stage (`data_out`/`valid_out` with no backpressure).
- Packs consecutive valid bytes little-endian into NUM_BYTES-wide words.
- Buffers completed words in a small first-word-fall-through FIFO and presents them on a valid/ready interface.
- Upstream cannot be stalled, so a word completing while the FIFO is full is dropped and a sticky overflow flag is raised.

---
 rtl/byte_word_packer.sv | 165 ++++++++++++++++
 tb/tb_byte_word_packer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer.sv
// byte_word_packer
//   Packs consecutive valid bytes from a non-stallable upstream byte stage,
//   little-endian, into NUM_BYTES-wide words. Completed or flushed words go
//   into a first-word-fall-through FIFO that drains over valid/ready. A word
//   that completes while the FIFO is full, with no pop in that cycle, is
//   dropped and the sticky overflow flag is raised.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   data_in         byte from upstream
//   valid_in        data_in valid this cycle (upstream cannot be stalled)
//   flush           push the current partial word, if any lanes are filled
//   clear_overflow  clears the sticky overflow flag
//   word_out        FIFO head word, byte k in bits [8k+7:8k], zero when empty
//   word_keep       FIFO head lane-valid mask, zero when empty
//   word_valid      FIFO non-empty
//   word_ready      consumer accepts the head word
//   fifo_level      number of stored words, 0..FIFO_DEPTH
//   overflow        sticky, set when a word is dropped

module byte_word_packer #(
   parameter int NUM_BYTES  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [7:0]                      data_in,
   input  logic                            valid_in,
   input  logic                            flush,
   input  logic                            clear_overflow,
   output logic [8*NUM_BYTES-1:0]          word_out,
   output logic [NUM_BYTES-1:0]            word_keep,
   output logic                            word_valid,
   input  logic                            word_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow
);

   localparam int WW   = 8 * NUM_BYTES;
   localparam int IDXW = $clog2(NUM_BYTES);
   localparam int PTRW = $clog2(FIFO_DEPTH);
   localparam int LVLW = PTRW + 1;

   // assembly state
   logic [IDXW-1:0]      idx_q, idx_d;
   logic [WW-1:0]        asm_q, asm_d;
   logic [NUM_BYTES-1:0] mask_q, mask_d;

   // FIFO state
   logic [WW-1:0]        mem_word_q [FIFO_DEPTH];
   logic [NUM_BYTES-1:0] mem_keep_q [FIFO_DEPTH];
   logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVLW-1:0]      level_q, level_d;
   logic                 overflow_q, overflow_d;

   // assembly word/mask including the byte arriving this cycle
   logic [WW-1:0]        asm_w;
   logic [NUM_BYTES-1:0] mask_w;
   logic                 complete;
   logic                 push_req;
   logic                 pop;
   logic                 full;
   logic                 push_ok;
   logic                 drop;

   always_comb begin
      asm_w  = asm_q;
      mask_w = mask_q;
      if (valid_in) begin
         asm_w[8*idx_q +: 8] = data_in;
         mask_w[idx_q]       = 1'b1;
      end
   end

   assign complete = valid_in && (idx_q == IDXW'(NUM_BYTES - 1));
   // a flush on the completing cycle folds into the single full-word push
   assign push_req = complete || (flush && (|mask_w));

   assign word_valid = (level_q != '0);
   assign full       = (level_q == LVLW'(FIFO_DEPTH));
   assign pop        = word_valid && word_ready;
   // a pop in the same cycle frees the slot the push needs
   assign push_ok    = push_req && (!full || pop);
   assign drop       = push_req && full && !pop;

   always_comb begin
      idx_d  = idx_q;
      asm_d  = asm_q;
      mask_d = mask_q;
      if (push_req) begin
         idx_d  = '0;
         asm_d  = '0;
         mask_d = '0;
      end else if (valid_in) begin
         idx_d  = idx_q + IDXW'(1);
         asm_d  = asm_w;
         mask_d = mask_w;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTRW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      case ({push_ok, pop})
         2'b10:   level_d = level_q + LVLW'(1);
         2'b01:   level_d = level_q - LVLW'(1);
         default: level_d = level_q;
      endcase
      // a drop outranks a simultaneous clear
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clear_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         asm_q      <= '0;
         mask_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         asm_q      <= asm_d;
         mask_q     <= mask_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_word_q[i] <= '0;
            mem_keep_q[i] <= '0;
         end
      end else if (push_ok) begin
         mem_word_q[wr_ptr_q] <= asm_w;
         mem_keep_q[wr_ptr_q] <= mask_w;
      end
   end

   // head is gated to zero when empty so stale entries never show
   assign word_out   = word_valid ? mem_word_q[rd_ptr_q] : '0;
   assign word_keep  = word_valid ? mem_keep_q[rd_ptr_q] : '0;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  data_in;
   logic        valid_in;
   logic        flush;
   logic        clear_overflow;
   logic [31:0] word_out;
   logic [3:0]  word_keep;
   logic        word_valid;
   logic        word_ready;
   logic [2:0]  fifo_level;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   byte_word_packer #(.NUM_BYTES(4), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_in        (data_in),
      .valid_in       (valid_in),
      .flush          (flush),
      .clear_overflow (clear_overflow),
      .word_out       (word_out),
      .word_keep      (word_keep),
      .word_valid     (word_valid),
      .word_ready     (word_ready),
      .fifo_level     (fifo_level),
      .overflow       (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      data_in  = b;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; data_in = '0; valid_in = 0; flush = 0;
      clear_overflow = 0; word_ready = 0;
      tick(); tick();
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", word_valid); end
      n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      n_cmp++; if (word_out !== 32'h0) begin n_err++; $display("FAIL reset_word: got %h want 0", word_out); end
      n_cmp++; if (word_keep !== 4'h0) begin n_err++; $display("FAIL reset_keep: got %h want 0", word_keep); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_pack();
      word_ready = 1'b1;
      send(8'h11); send(8'h22); send(8'h33);
      data_in = 8'h44; valid_in = 1'b1;
      #1;
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL basic_no_comb: got %b want 0", word_valid); end
      tick();
      valid_in = 1'b0;
      n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", word_valid); end
      n_cmp++; if (word_out !== 32'h44332211) begin n_err++; $display("FAIL basic_word: got %h want 44332211", word_out); end
      n_cmp++; if (word_keep !== 4'hF) begin n_err++; $display("FAIL basic_keep: got %h want f", word_keep); end
      tick();
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle: got %b want 0", word_valid); end
      n_cmp++; if (word_out !== 32'h0) begin n_err++; $display("FAIL basic_empty_word: got %h want 0", word_out); end
      word_ready = 1'b0;
   endtask

   task automatic test_partial_flush();
      word_ready = 1'b0;
      send(8'hAA); send(8'hBB);
      flush = 1'b1; tick(); flush = 1'b0;
      n_cmp++; if (word_out !== 32'h0000BBAA) begin n_err++; $display("FAIL pflush_word: got %h want 0000bbaa", word_out); end
      n_cmp++; if (word_keep !== 4'h3) begin n_err++; $display("FAIL pflush_keep: got %h want 3", word_keep); end
      send(8'hCC);
      flush = 1'b1; tick(); flush = 1'b0;
      n_cmp++; if (fifo_level !== 3'd2) begin n_err++; $display("FAIL pflush_level: got %0d want 2", fifo_level); end
      word_ready = 1'b1; tick();
      n_cmp++; if (word_out !== 32'h000000CC) begin n_err++; $display("FAIL pflush_lane0: got %h want 000000cc", word_out); end
      n_cmp++; if (word_keep !== 4'h1) begin n_err++; $display("FAIL pflush_lane0_keep: got %h want 1", word_keep); end
      tick();
      word_ready = 1'b0;
      n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL pflush_drained: got %0d want 0", fifo_level); end
   endtask

   task automatic test_flush_with_byte();
      send(8'h01); send(8'h02);
      data_in = 8'h03; valid_in = 1'b1; flush = 1'b1;
      tick();
      valid_in = 1'b0; flush = 1'b0;
      n_cmp++; if (word_out !== 32'h00030201) begin n_err++; $display("FAIL fbyte_word: got %h want 00030201", word_out); end
      n_cmp++; if (word_keep !== 4'h7) begin n_err++; $display("FAIL fbyte_keep: got %h want 7", word_keep); end
      flush = 1'b1; tick(); flush = 1'b0;
      n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL idle_flush_level: got %0d want 1", fifo_level); end
      word_ready = 1'b1; tick(); word_ready = 1'b0;
      n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL fbyte_drained: got %0d want 0", fifo_level); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      word_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(8'(i));
      n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL ovf_full_level: got %0d want 4", fifo_level); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_not_yet: got %b want 0", overflow); end
      for (int i = 16; i < 20; i++) send(8'(i));
      n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
      word_ready = 1'b1;
      for (int w = 0; w < 4; w++) begin
         exp = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
         n_cmp++; if (word_out !== exp) begin n_err++; $display("FAIL ovf_drain%0d: got %h want %h", w, word_out, exp); end
         tick();
      end
      word_ready = 1'b0;
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %b want 0", word_valid); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] exp;
      word_ready = 1'b0;
      for (int i = 8'h20; i < 8'h30; i++) send(8'(i));
      send(8'h30); send(8'h31); send(8'h32);
      data_in = 8'h33; valid_in = 1'b1; word_ready = 1'b1;
      tick();
      valid_in = 1'b0; word_ready = 1'b0;
      n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL pp_level: got %0d want 4", fifo_level); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_no_drop: got %b want 0", overflow); end
      word_ready = 1'b1;
      for (int w = 1; w < 5; w++) begin
         exp = {8'(8'h20+4*w+3), 8'(8'h20+4*w+2), 8'(8'h20+4*w+1), 8'(8'h20+4*w)};
         n_cmp++; if (word_out !== exp) begin n_err++; $display("FAIL pp_order%0d: got %h want %h", w, word_out, exp); end
         tick();
      end
      word_ready = 1'b0;
      n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL pp_drained: got %0d want 0", fifo_level); end
   endtask

   task automatic test_clear_priority();
      for (int i = 8'h40; i < 8'h50; i++) send(8'(i));
      send(8'h50); send(8'h51); send(8'h52);
      data_in = 8'h53; valid_in = 1'b1; clear_overflow = 1'b1;
      tick();
      valid_in = 1'b0; clear_overflow = 1'b0;
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL prio_drop_wins: got %b want 1", overflow); end
      n_cmp++; if (word_out !== 32'h43424140) begin n_err++; $display("FAIL prio_head: got %h want 43424140", word_out); end
      clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL prio_clear: got %b want 0", overflow); end
   endtask

   task automatic test_reset_mid();
      word_ready = 1'b1; tick(); tick(); word_ready = 1'b0;
      n_cmp++; if (fifo_level !== 3'd2) begin n_err++; $display("FAIL rmid_level_pre: got %0d want 2", fifo_level); end
      send(8'h60); send(8'h61);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", word_valid); end
      n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rmid_level: got %0d want 0", fifo_level); end
      tick();
      #2 rst_n = 1'b1;
      send(8'h70); send(8'h71); send(8'h72); send(8'h73);
      n_cmp++; if (word_out !== 32'h73727170) begin n_err++; $display("FAIL rmid_word: got %h want 73727170", word_out); end
      n_cmp++; if (word_keep !== 4'hF) begin n_err++; $display("FAIL rmid_keep: got %h want f", word_keep); end
      n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL rmid_level_post: got %0d want 1", fifo_level); end
   endtask

   initial begin
      test_reset();
      test_basic_pack();
      test_partial_flush();
      test_flush_with_byte();
      test_overflow();
      test_full_push_pop();
      test_clear_priority();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
